// File: rtl/clk_en_gen_pkg.sv
// Shared definitions for the clock-enable generator: channel limit, lock FSM
// encoding, default widths and a counter-width helper.
package clk_en_gen_pkg;

  localparam int unsigned CLK_GEN_CH_MAX          = 8;
  localparam int unsigned CLK_GEN_DIV_WIDTH_DEF   = 16;
  localparam int unsigned CLK_GEN_LOCK_CYCLES_DEF = 16;

  typedef enum logic {
    CLK_GEN_LOCKING = 1'b0,
    CLK_GEN_LOCKED  = 1'b1
  } lock_state_e;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// One divider channel: down-counter, divisor latch and registered
// ce / ce_tgl strobes. Optional half-period strobe ce180 when
// CLK_EN_GEN_PHASE_EN is defined.
module clk_en_div #(
  parameter int unsigned DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 ce,
  output logic                 ce_tgl
`ifdef CLK_EN_GEN_PHASE_EN
  ,
  output logic                 ce180
`endif
);

  localparam int unsigned HW = DIV_WIDTH + 1;

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] d_lat_q, d_lat_d;
  logic                 started_q, started_d;
  logic                 ce_q, ce_d;
  logic                 tgl_q, tgl_d;
`ifdef CLK_EN_GEN_PHASE_EN
  logic                 ce180_q, ce180_d;
  logic [HW-1:0]        half_c;

  // Half-period match point; one extra bit so D = max cannot overflow.
  assign half_c = ({1'b0, d_lat_q} + HW'(1)) >> 1;
`endif

  // Next-state: hold while not running, load on first run cycle, then count down and wrap.
  always_comb begin
    cnt_d     = cnt_q;
    d_lat_d   = d_lat_q;
    started_d = started_q;
    ce_d      = 1'b0;
    tgl_d     = tgl_q;
`ifdef CLK_EN_GEN_PHASE_EN
    ce180_d   = 1'b0;
`endif
    if (!run) begin
      cnt_d     = '0;
      started_d = 1'b0;
    end else if (!started_q) begin
      started_d = 1'b1;
      d_lat_d   = div;
      cnt_d     = div;
    end else if (cnt_q == '0) begin
      ce_d    = 1'b1;
      tgl_d   = ~tgl_q;
      d_lat_d = div;
      cnt_d   = div;
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
`ifdef CLK_EN_GEN_PHASE_EN
      // cnt is nonzero here, so D = 0 never collides with ce.
      ce180_d = ({1'b0, cnt_q} == half_c);
`endif
    end
  end

  // Channel registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      d_lat_q   <= '0;
      started_q <= 1'b0;
      ce_q      <= 1'b0;
      tgl_q     <= 1'b0;
`ifdef CLK_EN_GEN_PHASE_EN
      ce180_q   <= 1'b0;
`endif
    end else begin
      cnt_q     <= cnt_d;
      d_lat_q   <= d_lat_d;
      started_q <= started_d;
      ce_q      <= ce_d;
      tgl_q     <= tgl_d;
`ifdef CLK_EN_GEN_PHASE_EN
      ce180_q   <= ce180_d;
`endif
    end
  end

  assign ce     = ce_q;
  assign ce_tgl = tgl_q;
`ifdef CLK_EN_GEN_PHASE_EN
  assign ce180  = ce180_q;
`endif

endmodule

// File: rtl/clk_en_gen.sv
// Clock-enable generator: lock FSM plus CH_NUM independent divider channels,
// all in the single clk domain. Define CLK_EN_GEN_PHASE_EN to add the ce180
// half-period strobe output.
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int unsigned CH_NUM      = 2,
  parameter int unsigned DIV_WIDTH   = CLK_GEN_DIV_WIDTH_DEF,
  parameter int unsigned LOCK_CYCLES = CLK_GEN_LOCK_CYCLES_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CH_NUM*DIV_WIDTH-1:0]   div,
  output logic                          locked,
  output logic [CH_NUM-1:0]             ce,
  output logic [CH_NUM-1:0]             ce_tgl
`ifdef CLK_EN_GEN_PHASE_EN
  ,
  output logic [CH_NUM-1:0]             ce180
`endif
);

  localparam int unsigned LCW = cnt_width(LOCK_CYCLES);

  lock_state_e    state_q, state_d;
  logic [LCW-1:0] lock_cnt_q, lock_cnt_d;

  // Lock FSM: count LOCK_CYCLES cycles after reset release, then stay locked.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      CLK_GEN_LOCKING: begin
        if (lock_cnt_q == LCW'(LOCK_CYCLES - 1)) begin
          state_d = CLK_GEN_LOCKED;
        end else begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end
      end
      CLK_GEN_LOCKED: begin
        state_d = CLK_GEN_LOCKED;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLK_GEN_LOCKING;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign locked = (state_q == CLK_GEN_LOCKED);

  // One divider per channel, gated by locked.
  for (genvar n = 0; n < CH_NUM; n++) begin : g_ch
    clk_en_div #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_div (
      .clk    (clk),
      .reset  (reset),
      .run    (locked),
      .div    (div[n*DIV_WIDTH +: DIV_WIDTH]),
      .ce     (ce[n]),
      .ce_tgl (ce_tgl[n])
`ifdef CLK_EN_GEN_PHASE_EN
      ,
      .ce180  (ce180[n])
`endif
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// Self-checking bench for clk_en_gen (CH_NUM=2, DIV_WIDTH=16, LOCK_CYCLES=16).
// Exercises ce180 only when CLK_EN_GEN_PHASE_EN is defined.
module tb_clk_en_gen;

  localparam int CH_NUM = 2;
  localparam int DW     = 16;
  localparam int LC     = 16;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [CH_NUM*DW-1:0]   div;
  logic                   locked;
  logic [CH_NUM-1:0]      ce;
  logic [CH_NUM-1:0]      ce_tgl;
`ifdef CLK_EN_GEN_PHASE_EN
  logic [CH_NUM-1:0]      ce180;
`endif

  int n_vec = 0;
  int n_err = 0;
  int          iq[$];
  logic [3:0]  vq[$];

  clk_en_gen #(
    .CH_NUM      (CH_NUM),
    .DIV_WIDTH   (DW),
    .LOCK_CYCLES (LC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .div    (div),
    .locked (locked),
    .ce     (ce),
    .ce_tgl (ce_tgl)
`ifdef CLK_EN_GEN_PHASE_EN
    ,
    .ce180  (ce180)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    div   = {16'd3, 16'd0};
    repeat (3) step();
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked: got %b expected 0", locked); end
    n_vec++; if (ce !== 2'b00) begin n_err++; $display("FAIL reset_ce: got %b expected 00", ce); end
    n_vec++; if (ce_tgl !== 2'b00) begin n_err++; $display("FAIL reset_ce_tgl: got %b expected 00", ce_tgl); end
  endtask

  task automatic test_lock();
    int edges;
    int e;
    bit early;
    edges = 0;
    early = 1'b0;
    iq.push_back(LC);
    reset = 1'b0;
    while (!locked && edges < 40) begin
      step();
      edges++;
      if (ce !== 2'b00) early = 1'b1;
    end
    e = iq.pop_front();
    n_vec++;
    if (locked !== 1'b1 || edges != e) begin
      n_err++; $display("FAIL lock_edges: got %0d (locked=%b) expected %0d", edges, locked, e);
    end
    n_vec++; if (early) begin n_err++; $display("FAIL lock_ce_quiet: got ce pulse expected none before lock"); end
  endtask

  // ch0 D=0 (every cycle), ch1 D=3 (every 4th cycle, tgl period 8).
  task automatic test_divide();
    logic [3:0] got;
    logic [3:0] e;
    logic t0;
    logic t1;
    logic c0;
    logic c1;
    t0 = 1'b0;
    t1 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      c0 = (k >= 2);
      c1 = (k >= 5) && (((k - 5) % 4) == 0);
      if (c0) t0 = ~t0;
      if (c1) t1 = ~t1;
      vq.push_back({t1, t0, c1, c0});
      step();
      got = {ce_tgl, ce};
      e   = vq.pop_front();
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL divide k=%0d: got tgl/ce %b expected %b", k, got, e); end
    end
  endtask

  // ch0: D=9, switch to D=2 when cnt==5; intervals 10,10 then 3s.
  task automatic test_div_change();
    int last;
    int e;
    last = -1;
    iq.push_back(10); iq.push_back(10); iq.push_back(3); iq.push_back(3); iq.push_back(3);
    div[15:0] = 16'd9;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (ce[0]) begin
        if (last >= 0) begin
          n_vec++;
          if (iq.size() == 0) begin
            n_err++; $display("FAIL div_change_extra: got pulse at k=%0d expected none", k);
          end else begin
            e = iq.pop_front();
            if (k - last != e) begin n_err++; $display("FAIL div_change_period: got %0d expected %0d", k - last, e); end
          end
        end
        last = k;
      end
      if (k == 15) div[15:0] = 16'd2;
    end
    n_vec++;
    if (iq.size() != 0) begin
      n_err++; $display("FAIL div_change_missing: got %0d pulses short expected 0", iq.size());
      iq.delete();
    end
  endtask

`ifdef CLK_EN_GEN_PHASE_EN
  // ch0 D=7: ce180 four cycles after each ce.
  task automatic test_phase();
    int w;
    logic [3:0] got;
    logic [3:0] e;
    div[15:0] = 16'd7;
    w = 0;
    while (ce[0] !== 1'b1 && w < 20) begin step(); w++; end
    n_vec++; if (ce[0] !== 1'b1) begin n_err++; $display("FAIL phase_sync: got no ce expected ce within 20"); end
    for (int k = 1; k <= 24; k++) begin
      vq.push_back({2'b00, 1'((k % 8) == 4), 1'((k % 8) == 0)});
      step();
      got = {2'b00, ce180[0], ce[0]};
      e   = vq.pop_front();
      n_vec++;
      if (got !== e) begin n_err++; $display("FAIL phase k=%0d: got ce180/ce %b expected %b", k, got[1:0], e[1:0]); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int edges;
    int e;
    int d0;
    int f0;
    int f1;
    reset = 1'b1;
    step();
    n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL mid_reset_locked: got %b expected 0", locked); end
    n_vec++; if (ce !== 2'b00) begin n_err++; $display("FAIL mid_reset_ce: got %b expected 00", ce); end
    n_vec++; if (ce_tgl !== 2'b00) begin n_err++; $display("FAIL mid_reset_ce_tgl: got %b expected 00", ce_tgl); end
    reset = 1'b0;
    iq.push_back(LC);
    edges = 0;
    while (!locked && edges < 40) begin step(); edges++; end
    e = iq.pop_front();
    n_vec++;
    if (locked !== 1'b1 || edges != e) begin
      n_err++; $display("FAIL relock_edges: got %0d (locked=%b) expected %0d", edges, locked, e);
    end
    d0 = int'(div[15:0]);
    iq.push_back(d0 + 2);
    iq.push_back(5);
    f0 = -1;
    f1 = -1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (ce[0] && f0 < 0) f0 = k;
      if (ce[1] && f1 < 0) f1 = k;
    end
    e = iq.pop_front();
    n_vec++; if (f0 != e) begin n_err++; $display("FAIL resume_ch0: got first ce at %0d expected %0d", f0, e); end
    e = iq.pop_front();
    n_vec++; if (f1 != e) begin n_err++; $display("FAIL resume_ch1: got first ce at %0d expected %0d", f1, e); end
  endtask

  // ch0 D=FFFF: exactly 65536 cycles between pulses, one toggle.
  task automatic test_max_div();
    int w;
    int n;
    int e;
    logic t;
    div[15:0] = 16'hFFFF;
    w = 0;
    while (ce[0] !== 1'b1 && w < 20) begin step(); w++; end
    n_vec++; if (ce[0] !== 1'b1) begin n_err++; $display("FAIL max_sync: got no ce expected ce within 20"); end
    t = ce_tgl[0];
    iq.push_back(65536);
    n = 0;
    do begin step(); n++; end while (ce[0] !== 1'b1 && n < 70000);
    e = iq.pop_front();
    n_vec++; if (n != e) begin n_err++; $display("FAIL max_period: got %0d expected %0d", n, e); end
    n_vec++; if (ce_tgl[0] !== ~t) begin n_err++; $display("FAIL max_tgl: got %b expected %b", ce_tgl[0], ~t); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_divide();
    test_div_change();
`ifdef CLK_EN_GEN_PHASE_EN
    test_phase();
`endif
    test_reset_mid();
    test_max_div();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
